// File: rtl/traffic_light_controller_param.sv
// Two-way intersection controller: green/yellow/all-red cycle, latched pedestrian walks, flashing-red mode.
// All outputs registered; next-state logic is a single combinational block feeding one always_ff.
module traffic_light_controller_param #(
    parameter int GREEN_TIME  = 8,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int MIN_GREEN   = 4,
    parameter int PED_TIME    = 3,
    parameter int FLASH_HALF  = 4,
    parameter int TIMER_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    input  logic       flash_mode,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk_ns,
    output logic       ped_walk_ew,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        FLASH     = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Timer values on the final cycle of each timed interval.
    localparam logic [TIMER_W-1:0] GREEN_LAST  = TIMER_W'(GREEN_TIME - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] ALLRED_LAST = TIMER_W'(ALLRED_TIME - 1);
    localparam logic [TIMER_W-1:0] MIN_LAST    = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] PED_LAST    = TIMER_W'(PED_TIME - 1);
    localparam logic [TIMER_W-1:0] FLASH_LAST  = TIMER_W'(FLASH_HALF - 1);

    state_t               state;
    state_t               state_nxt;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_nxt;
    logic                 flash_tog;
    logic                 flash_tog_nxt;
    logic                 ped_pend_ns;
    logic                 ped_pend_ew;
    logic                 pend_ns_nxt;
    logic                 pend_ew_nxt;
    logic                 walk_ns_nxt;
    logic                 walk_ew_nxt;
    logic                 enter_ns;
    logic                 enter_ew;

    function automatic logic [5:0] lamps(input state_t s, input logic tog);
        logic [5:0] l;
        l = {LAMP_RED, LAMP_RED};
        case (s)
            NS_GREEN:  l = {LAMP_GRN, LAMP_RED};
            NS_YELLOW: l = {LAMP_YEL, LAMP_RED};
            EW_GREEN:  l = {LAMP_RED, LAMP_GRN};
            EW_YELLOW: l = {LAMP_RED, LAMP_YEL};
            FLASH:     l = tog ? {LAMP_OFF, LAMP_OFF} : {LAMP_RED, LAMP_RED};
            default:   l = {LAMP_RED, LAMP_RED};
        endcase
        return l;
    endfunction

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer + 1'b1;
        flash_tog_nxt = flash_tog;
        case (state)
            NS_GREEN: begin
                if (timer == GREEN_LAST || (ped_pend_ew && timer >= MIN_LAST)) begin
                    state_nxt = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                if (timer == YELLOW_LAST) begin
                    state_nxt = ALLRED_A;
                end
            end
            ALLRED_A: begin
                if (timer == ALLRED_LAST) begin
                    state_nxt = flash_mode ? FLASH : EW_GREEN;
                end
            end
            EW_GREEN: begin
                if (timer == GREEN_LAST || (ped_pend_ns && timer >= MIN_LAST)) begin
                    state_nxt = EW_YELLOW;
                end
            end
            EW_YELLOW: begin
                if (timer == YELLOW_LAST) begin
                    state_nxt = ALLRED_B;
                end
            end
            ALLRED_B: begin
                if (timer == ALLRED_LAST) begin
                    state_nxt = flash_mode ? FLASH : NS_GREEN;
                end
            end
            FLASH: begin
                // Leaving flash always goes through a full all-red clearance.
                if (!flash_mode) begin
                    state_nxt = ALLRED_B;
                end else if (timer == FLASH_LAST) begin
                    flash_tog_nxt = ~flash_tog;
                    timer_nxt     = '0;
                end
            end
            default: begin
                state_nxt = NS_GREEN;
            end
        endcase

        // Every state change restarts the timer and clears the flash phase.
        if (state_nxt != state) begin
            timer_nxt     = '0;
            flash_tog_nxt = 1'b0;
        end

        enter_ns = (state_nxt == NS_GREEN) && (state != NS_GREEN);
        enter_ew = (state_nxt == EW_GREEN) && (state != EW_GREEN);

        // Entering a green consumes the pending request; requests during own green are already served.
        pend_ns_nxt = enter_ns ? 1'b0 : (ped_pend_ns | (ped_req_ns && state != NS_GREEN));
        pend_ew_nxt = enter_ew ? 1'b0 : (ped_pend_ew | (ped_req_ew && state != EW_GREEN));

        if (enter_ns) begin
            walk_ns_nxt = ped_pend_ns;
        end else if (state_nxt != NS_GREEN || timer == PED_LAST) begin
            walk_ns_nxt = 1'b0;
        end else begin
            walk_ns_nxt = ped_walk_ns;
        end

        if (enter_ew) begin
            walk_ew_nxt = ped_pend_ew;
        end else if (state_nxt != EW_GREEN || timer == PED_LAST) begin
            walk_ew_nxt = 1'b0;
        end else begin
            walk_ew_nxt = ped_walk_ew;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= NS_GREEN;
            timer       <= '0;
            flash_tog   <= 1'b0;
            ped_pend_ns <= 1'b0;
            ped_pend_ew <= 1'b0;
            ped_walk_ns <= 1'b0;
            ped_walk_ew <= 1'b0;
            ns_light    <= LAMP_GRN;
            ew_light    <= LAMP_RED;
            phase       <= 3'd0;
        end else begin
            state                  <= state_nxt;
            timer                  <= timer_nxt;
            flash_tog              <= flash_tog_nxt;
            ped_pend_ns            <= pend_ns_nxt;
            ped_pend_ew            <= pend_ew_nxt;
            ped_walk_ns            <= walk_ns_nxt;
            ped_walk_ew            <= walk_ew_nxt;
            {ns_light, ew_light}   <= lamps(state_nxt, flash_tog_nxt);
            phase                  <= state_nxt;
        end
    end

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Directed scenarios plus random requests/flash/reset, checked each cycle against a phase/duration model.
module tb_traffic_light_controller_param;

    localparam int GREEN_TIME  = 8;
    localparam int YELLOW_TIME = 3;
    localparam int ALLRED_TIME = 2;
    localparam int MIN_GREEN   = 4;
    localparam int PED_TIME    = 3;
    localparam int FLASH_HALF  = 4;
    localparam int TIMER_W     = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       ped_req_ns;
    logic       ped_req_ew;
    logic       flash_mode;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       ped_walk_ns;
    logic       ped_walk_ew;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;
    int c     = 0;

    // Model: phase number (0..6 as listed in the phase table), cycles spent in it, flash half, pending and grant bits.
    int m_ph  = 0;
    int m_t   = 0;
    bit m_tog = 1'b0;
    bit m_pn  = 1'b0;
    bit m_pe  = 1'b0;
    bit m_gn  = 1'b0;
    bit m_ge  = 1'b0;

    traffic_light_controller_param #(
        .GREEN_TIME(GREEN_TIME), .YELLOW_TIME(YELLOW_TIME), .ALLRED_TIME(ALLRED_TIME),
        .MIN_GREEN(MIN_GREEN), .PED_TIME(PED_TIME), .FLASH_HALF(FLASH_HALF), .TIMER_W(TIMER_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ped_req_ns(ped_req_ns),
        .ped_req_ew(ped_req_ew),
        .flash_mode(flash_mode),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .ped_walk_ns(ped_walk_ns),
        .ped_walk_ew(ped_walk_ew),
        .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, c);
        end
    endtask

    function automatic logic [2:0] exp_ns(input int ph, input bit tog);
        case (ph)
            0:       return 3'b001;
            1:       return 3'b010;
            6:       return tog ? 3'b000 : 3'b100;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_ew(input int ph, input bit tog);
        case (ph)
            3:       return 3'b001;
            4:       return 3'b010;
            6:       return tog ? 3'b000 : 3'b100;
            default: return 3'b100;
        endcase
    endfunction

    task automatic model_step(input bit rn, input bit re, input bit fl, input bit rs);
        int nph;
        if (rs) begin
            m_ph = 0; m_t = 0; m_tog = 0; m_pn = 0; m_pe = 0; m_gn = 0; m_ge = 0;
            return;
        end
        nph = m_ph;
        case (m_ph)
            0: if (m_t + 1 >= GREEN_TIME || (m_pe && m_t + 1 >= MIN_GREEN)) nph = 1;
            1: if (m_t + 1 >= YELLOW_TIME) nph = 2;
            2: if (m_t + 1 >= ALLRED_TIME) nph = fl ? 6 : 3;
            3: if (m_t + 1 >= GREEN_TIME || (m_pn && m_t + 1 >= MIN_GREEN)) nph = 4;
            4: if (m_t + 1 >= YELLOW_TIME) nph = 5;
            5: if (m_t + 1 >= ALLRED_TIME) nph = fl ? 6 : 0;
            default: begin
                if (!fl) nph = 5;
                else if (m_t + 1 >= FLASH_HALF) begin
                    m_tog = !m_tog;
                    m_t   = -1;
                end
            end
        endcase
        if (nph == 0 && m_ph != 0) begin m_gn = m_pn; m_pn = 0; end
        else if (rn && m_ph != 0) m_pn = 1;
        if (nph == 3 && m_ph != 3) begin m_ge = m_pe; m_pe = 0; end
        else if (re && m_ph != 3) m_pe = 1;
        if (nph != m_ph) begin m_t = 0; m_tog = 0; end
        else m_t++;
        m_ph = nph;
    endtask

    task automatic compare_all();
        bit wn;
        bit we;
        wn = (m_ph == 0) && m_gn && (m_t < PED_TIME);
        we = (m_ph == 3) && m_ge && (m_t < PED_TIME);
        check("phase", 32'(phase), 32'(m_ph));
        check("ns_light", 32'(ns_light), 32'(exp_ns(m_ph, m_tog)));
        check("ew_light", 32'(ew_light), 32'(exp_ew(m_ph, m_tog)));
        check("walk_ns", 32'(ped_walk_ns), 32'(wn));
        check("walk_ew", 32'(ped_walk_ew), 32'(we));
        check("no_conflict", 32'(ns_light[1:0] != 2'b00 && ew_light[1:0] != 2'b00), 0);
        check("walk_ns_in_green", 32'(ped_walk_ns && ns_light != 3'b001), 0);
        check("walk_ew_in_green", 32'(ped_walk_ew && ew_light != 3'b001), 0);
        check("phase_range", 32'(phase <= 3'd6), 1);
    endtask

    // Drive inputs for the current cycle, advance one edge, then check the new cycle.
    task automatic cycle(input bit rn, input bit re, input bit fl, input bit rs);
        ped_req_ns = rn;
        ped_req_ew = re;
        flash_mode = fl;
        reset      = rs;
        @(posedge clk);
        #1;
        model_step(rn, re, fl, rs);
        c = rs ? 0 : c + 1;
        compare_all();
    endtask

    initial begin
        bit fl;
        ped_req_ns = 0; ped_req_ew = 0; flash_mode = 0; reset = 1;

        // Plain cycle with no requests.
        cycle(0, 0, 0, 1);
        check("rst_ns", 32'(ns_light), 32'b001);
        check("rst_ew", 32'(ew_light), 32'b100);
        check("rst_phase", 32'(phase), 0);
        for (int i = 0; i < 27; i++) begin
            cycle(0, 0, 0, 0);
            if (c == 7)  check("s1_green_last", 32'(phase), 0);
            if (c == 8)  check("s1_yellow", 32'(phase), 1);
            if (c == 11) check("s1_allred_a", 32'(phase), 2);
            if (c == 13) check("s1_ew_green", 32'(phase), 3);
            if (c == 21) check("s1_ew_yellow", 32'(phase), 4);
            if (c == 24) check("s1_allred_b", 32'(phase), 5);
            if (c == 26) check("s1_ns_again", 32'(phase), 0);
        end

        // EW pedestrian pulse forces early NS exit.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            cycle(0, c == 1, 0, 0);
            if (c == 3)  check("s2_still_green", 32'(phase), 0);
            if (c == 4)  check("s2_early_yellow", 32'(phase), 1);
            if (c == 9)  check("s2_ew_green", 32'(phase), 3);
            if (c == 9)  check("s2_walk_start", 32'(ped_walk_ew), 1);
            if (c == 11) check("s2_walk_last", 32'(ped_walk_ew), 1);
            if (c == 12) check("s2_walk_end", 32'(ped_walk_ew), 0);
        end

        // NS request during own green is ignored.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 27; i++) begin
            cycle(c <= 7, 0, 0, 0);
            if (c == 20) check("s3_ew_full", 32'(phase), 3);
            if (c == 21) check("s3_ew_yellow", 32'(phase), 4);
            if (c == 26) check("s3_ns_again", 32'(ped_walk_ns), 0);
        end

        // Flash entry via all-red, toggling, and exit through all-red.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 27; i++) begin
            cycle(0, 0, c >= 2 && c <= 21, 0);
            if (c == 10) check("s4_yellow_done", 32'(phase), 1);
            if (c == 13) check("s4_flash", 32'(phase), 6);
            if (c == 16) check("s4_on_last", 32'(ns_light), 32'b100);
            if (c == 17) check("s4_off", 32'(ew_light), 32'b000);
            if (c == 21) check("s4_on_again", 32'(ns_light), 32'b100);
            if (c == 23) check("s4_allred_b", 32'(phase), 5);
            if (c == 25) check("s4_ns_green", 32'(phase), 0);
        end

        // Mid-operation reset with an NS request pending.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 15; i++) cycle(c == 9, 0, 0, 0);
        check("s5_in_ew_green", 32'(phase), 3);
        cycle(0, 0, 0, 1);
        check("s5_rst_ns", 32'(ns_light), 32'b001);
        check("s5_rst_ew", 32'(ew_light), 32'b100);
        check("s5_rst_phase", 32'(phase), 0);
        for (int i = 0; i < 30; i++) begin
            cycle(0, 0, 0, 0);
            if (c == 20) check("s5_ew_full", 32'(phase), 3);
            if (c == 26) check("s5_no_walk", 32'(ped_walk_ns), 0);
        end

        // Random requests, flash periods and occasional resets.
        fl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) fl = !fl;
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, fl,
                  $urandom_range(0, 499) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_controller_param.md
Name: traffic_light_controller_param

Overview:
Parametrised next-generation two-way intersection controller. Timings are set by parameters. An all-red clearance phase sits between opposing greens. Per-direction pedestrian requests are latched, give a walk interval and may end the opposing green early. A safe flashing-red mode is entered and left only through all-red.

Parameters:
GREEN_TIME, 8, green duration in cycles (>=1)
YELLOW_TIME, 3, yellow duration in cycles (>=1)
ALLRED_TIME, 2, all-red clearance duration in cycles (>=1)
MIN_GREEN, 4, minimum green before a pedestrian early exit (1..GREEN_TIME)
PED_TIME, 3, walk duration at start of green (1..MIN_GREEN)
FLASH_HALF, 4, flash half-period in cycles (>=1)
TIMER_W, 8, phase timer width; every duration must be <= 2**TIMER_W

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ped_req_ns  in  1  pedestrian request to cross alongside NS traffic; single-cycle pulse or level
ped_req_ew  in  1  pedestrian request to cross alongside EW traffic
flash_mode  in  1  request for flashing-red mode; level
ns_light  out  3  NS lamps {red,yellow,green}
ew_light  out  3  EW lamps {red,yellow,green}
ped_walk_ns  out  1  NS walk indication
ped_walk_ew  out  1  EW walk indication
phase  out  3  current state encoding, for debug and status

Behaviour:
- Single clock domain: clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- All outputs are decoded only from registers: state, timer, walk flags and flash toggle.
- Reset state: NS_GREEN, timer=0, both ped pending=0, walk flags=0, flash toggle=0. Outputs: ns_light=001, ew_light=100, walks=0, phase=0.
- Reset asserted mid-operation forces the reset state on the next edge, from any state including FLASH.
- Cycle 0 is the first edge with reset low. That cycle counts as green cycle 0.
- Timer counts up from 0 on each state entry and increments every cycle. A state is left on the cycle its exit condition holds. The next state starts with timer=0.
- States, with phase encoding and lamps:
  - NS_GREEN (0): ns 001, ew 100
  - NS_YELLOW (1): ns 010, ew 100
  - ALLRED_A (2): both 100
  - EW_GREEN (3): ns 100, ew 001
  - EW_YELLOW (4): ns 100, ew 010
  - ALLRED_B (5): both 100
  - FLASH (6): both 100 when toggle=0, both 000 when toggle=1
- Transitions:
  - NS_GREEN -> NS_YELLOW when timer==GREEN_TIME-1, or when ped_pend_ew and timer>=MIN_GREEN-1.
  - NS_YELLOW -> ALLRED_A when timer==YELLOW_TIME-1.
  - ALLRED_A -> EW_GREEN when timer==ALLRED_TIME-1.
  - EW_GREEN -> EW_YELLOW: symmetric to NS_GREEN, using ped_pend_ns.
  - EW_YELLOW -> ALLRED_B when timer==YELLOW_TIME-1.
  - ALLRED_B -> NS_GREEN when timer==ALLRED_TIME-1.
  - Either ALLRED state at its final cycle with flash_mode=1 -> FLASH instead of the next green.
  - FLASH with flash_mode=0 -> ALLRED_B (full ALLRED_TIME), then NS_GREEN.
- flash_mode has no effect in green or yellow states. Those phases always complete normally.
- FLASH: toggle starts at 0 on entry and inverts every FLASH_HALF cycles. The timer resets to 0 on each toggle.
- Pedestrian pending latch, per direction:
  - Set when the request is high and that direction is not in its green state.
  - Requests are ignored while that direction's green is active; the request is treated as served.
  - Pending also latches during FLASH.
- On entry to a direction's green:
  - If that direction's pending flag is 1, it clears and the walk flag sets.
  - Walk is high for green cycles 0..PED_TIME-1, then low.
  - If the green ends before that point, walk drops when the green ends.
- Walk is never high outside the matching green.
- NS and EW are never non-red together.
- The timer never wraps, because durations are bounded by the parameter constraints.

Test Plan:
1. Default params, no requests → NS_GREEN cycles 0-7, NS_YELLOW 8-10, ALLRED_A 11-12, EW_GREEN 13-20, EW_YELLOW 21-23, ALLRED_B 24-25, NS_GREEN again at cycle 26. Walks stay 0.
2. ped_req_ew pulsed at cycle 1 → NS_YELLOW at cycle 4 (early exit after MIN_GREEN). EW_GREEN at cycle 9. ped_walk_ew=1 for cycles 9-11. ped_pend_ew clears at cycle 9.
3. ped_req_ns held high through NS_GREEN cycles 0-7 → no pending, no early exit of EW_GREEN. Timing is identical to scenario 1.
4. flash_mode raised at cycle 2 → normal sequence to ALLRED_A ends at cycle 12. FLASH from cycle 13: lamps 100 for cycles 13-16, 000 for 17-20, 100 for 21-24. flash_mode dropped at cycle 22 → ALLRED_B at cycles 23-24, NS_GREEN at 25.
5. reset asserted at cycle 15 (EW_GREEN, with ped_req_ns pending) → next cycle shows ns=001, ew=100, phase=0, pending cleared, walks 0.
6. Checker every cycle: never both directions non-red; walk only in its own green; phase always in 0-6.
